// File: rtl/if_id_fifo.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO of {instr, pc}
// with valid/ready on both sides, single-cycle branch flush and NOP bubble when empty.
module if_id_fifo #(
   parameter int              ILEN      = 32,
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 2,
   parameter logic [ILEN-1:0] NOP_INSTR = {ILEN{1'b0}}
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [ILEN-1:0]            in_instr,
   input  logic [XLEN-1:0]            in_pc,
   output logic                       in_ready,
   input  logic                       flush,
   input  logic [XLEN-1:0]            flush_pc,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [ILEN-1:0]            Instruction,
   output logic [XLEN-1:0]            pc_out,
   output logic [$clog2(DEPTH):0]     count,
   output logic [15:0]                flushed_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [ILEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [XLEN-1:0] pc_hold;
   logic            push;
   logic            pop;
   logic [16:0]     flush_sum;

   // Handshake flags come purely from registered state, never from out_ready.
   assign in_ready  = (count < DEPTH_C);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign flush_sum = {1'b0, flushed_cnt} + 17'(count);

   assign Instruction = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
   assign pc_out      = out_valid ? pc_mem[rd_ptr]    : pc_hold;

   // Storage is deliberately left out of reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= in_instr;
         pc_mem[wr_ptr]    <= in_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pc_hold     <= '0;
         flushed_cnt <= '0;
      end else if (flush) begin
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pc_hold     <= flush_pc;
         flushed_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + PW'(1);
            pc_hold <= pc_mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

Parametrised fetch-to-decode buffer replacing the single-entry IF/ID register. It holds up to DEPTH fetched instruction/PC pairs between the fetch stage and decode, decoupling fetch stalls from decode stalls with a valid/ready handshake on each side. Branch flush empties the buffer in one cycle and redirects the presented PC. Decode sees a NOP bubble whenever the buffer is empty.

## Interface

Parameters:
- ILEN, 32: instruction width in bits.
- XLEN, 32: PC width in bits.
- DEPTH, 2: number of entries; power of two, ≥ 2.
- NOP_INSTR, 32'h0000_0000: instruction value presented when empty.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch offers an entry this cycle.
- in_instr  input  ILEN  fetched instruction.
- in_pc  input  XLEN  PC of in_instr.
- in_ready  output  1  buffer can accept an entry this cycle.
- flush  input  1  branch/jump redirect; discards all buffered entries.
- flush_pc  input  XLEN  redirect target PC, captured on flush.
- out_ready  input  1  decode consumes the head entry this cycle (successor of the old write-enable; 0 = decode stalled).
- out_valid  output  1  head entry is valid.
- Instruction  output  ILEN  head instruction, or NOP_INSTR when empty.
- pc_out  output  XLEN  head PC, or held PC when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- flushed_cnt  output  16  saturating count of entries discarded by flush.

## Operation

- Storage: circular array of DEPTH {instr, pc} entries, write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- in_ready = (count < DEPTH). It depends only on state, never combinationally on out_ready.
- out_valid = (count != 0).
- Push: occurs when in_valid && in_ready && !flush. Writes the entry at wr_ptr, then wr_ptr+1.
- Pop: occurs when out_valid && out_ready && !flush. Advances rd_ptr+1. pc_hold <= popped PC.
- Simultaneous push and pop: both happen and count is unchanged. Legal at full only if in_ready was already 1; at full, in_ready=0, so only the pop happens.
- Flush has highest priority:
  - count, wr_ptr and rd_ptr go to 0.
  - Push and pop that cycle are ignored.
  - pc_hold <= flush_pc.
  - flushed_cnt += count, saturating at 16'hFFFF.
- Outputs when empty: Instruction = NOP_INSTR, pc_out = pc_hold (last popped PC or last flush target).
- Outputs when not empty: Instruction = entry[rd_ptr].instr, pc_out = entry[rd_ptr].pc.
- Reset (asynchronous, immediate):
  - count, wr_ptr, rd_ptr = 0; pc_hold = 0; flushed_cnt = 0.
  - Hence out_valid = 0, Instruction = NOP_INSTR, pc_out = 0, in_ready = 1.
  - Storage contents are not reset. Reset mid-operation discards all entries and does not increment flushed_cnt.
- in_valid with in_ready=0: no state change. Fetch must hold the entry; this is not checked internally.

## Timing

- Through-latency is one cycle, with no empty bypass: an entry pushed at edge N appears on Instruction/pc_out/out_valid after edge N.
- Pop takes effect at the edge. The next head (or NOP/pc_hold) is presented after that edge.
- in_ready and out_valid update only on clock edges or reset assertion.
- Flush at edge N:
  - After edge N: out_valid=0, pc_out=flush_pc, in_ready=1.
  - The first post-flush fetch can be pushed at edge N+1.
- Sustained throughput is one entry per cycle when in_valid and out_ready are both held high, provided count < DEPTH.
- Pointer wrap: with DEPTH=2, push/pop streams of ≥ 5 entries must preserve order across the wrap.

## Test plan

- Reset: assert rst mid-cycle with 2 entries buffered -> immediately out_valid=0, Instruction=0, pc_out=0, count=0, in_ready=1, flushed_cnt=0.
- Fill/stall: DEPTH=2, out_ready=0, push PC 0x00, 0x04 -> count=2, in_ready=0, a third push (0x08) is ignored. Then set out_ready=1 -> outputs 0x00, then 0x04, then empty with pc_out=0x04.
- Streaming with wrap: in_valid=out_ready=1 for 8 cycles, PCs 0x00..0x1C -> decode receives them in order, one per cycle after a 1-cycle latency, and count stays at 1.
- Flush priority: count=2, flush=1 with flush_pc=0x200, and in_valid=1 and out_ready=1 the same cycle -> next cycle count=0, out_valid=0, pc_out=0x200, Instruction=NOP_INSTR, flushed_cnt=2, and the pushed entry is not stored.
- Simultaneous push/pop at count=1 -> count stays 1, and the head becomes the newly pushed entry next cycle.
- flushed_cnt saturation: preload by repeated fill+flush until the counter reaches 16'hFFFE, then flush with count=2 -> flushed_cnt=16'hFFFF, and it stays there on further flushes.
